// File: rtl/wavepool_fetch_scheduler_pkg.sv
// Shared sizes, FSM encoding and id helper for the wavepool fetch scheduler.
package wavepool_fetch_scheduler_pkg;
  localparam int NUM_WF  = 40;
  localparam int WF_ID_W = 6;
  localparam int PC_W    = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } fetch_state_e;

  function automatic logic [WF_ID_W-1:0] wf_next(input logic [WF_ID_W-1:0] id);
    return (id == WF_ID_W'(NUM_WF - 1)) ? '0 : id + 1'b1;
  endfunction
endpackage

// File: rtl/wavepool_fetch_scheduler_rr_arbiter_40.sv
// Rotating-priority picker: first set request at or after base, wrapping at NUM_WF.
module rr_arbiter_40
  import wavepool_fetch_scheduler_pkg::*;
(
  input  logic [NUM_WF-1:0]  req,
  input  logic [WF_ID_W-1:0] base,
  output logic [NUM_WF-1:0]  grant,
  output logic [WF_ID_W-1:0] grant_id,
  output logic               any
);
  logic [WF_ID_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_WF; k++) begin
      idx = WF_ID_W'((int'(base) + k) % NUM_WF);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end
endmodule

// File: rtl/wavepool_fetch_scheduler.sv
// Picks the next wavefront to refill, issues one fetch at a time, and drives per-slot queue controls.
module wavepool_fetch_scheduler
  import wavepool_fetch_scheduler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               disp_valid,
  input  logic [WF_ID_W-1:0] disp_wfid,
  input  logic [PC_W-1:0]    disp_pc,
  input  logic               halt_valid,
  input  logic [WF_ID_W-1:0] halt_wfid,
  input  logic               br_valid,
  input  logic [WF_ID_W-1:0] br_wfid,
  input  logic [PC_W-1:0]    br_target,
  input  logic [NUM_WF-1:0]  stop_fetch,
  output logic               fetch_req_valid,
  input  logic               fetch_req_ready,
  output logic [WF_ID_W-1:0] fetch_req_wfid,
  output logic [PC_W-1:0]    fetch_req_pc,
  input  logic               fetch_rsp_valid,
  input  logic [WF_ID_W-1:0] fetch_rsp_wfid,
  output logic [NUM_WF-1:0]  q_vtail_incr,
  output logic [NUM_WF-1:0]  q_wr,
  output logic [NUM_WF-1:0]  q_reset
);
  fetch_state_e state_q, state_d;

  logic [NUM_WF-1:0]  active_q, pending_q, drop_q;
  logic [PC_W-1:0]    pc_q [NUM_WF];
  logic [WF_ID_W-1:0] rr_ptr_q, req_wfid_q;
  logic [PC_W-1:0]    req_pc_q;
  logic               req_kill_q;

  logic [NUM_WF-1:0]  disp_hit, halt_hit, br_hit, rsp_hit, eligible, grant;
  logic [WF_ID_W-1:0] grant_id;
  logic               grant_any, pick, accept, req_hit;

  always_comb begin
    disp_hit = '0;
    halt_hit = '0;
    br_hit   = '0;
    rsp_hit  = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      disp_hit[i] = disp_valid      && (disp_wfid      == WF_ID_W'(i));
      halt_hit[i] = halt_valid      && (halt_wfid      == WF_ID_W'(i));
      br_hit[i]   = br_valid        && (br_wfid        == WF_ID_W'(i));
      rsp_hit[i]  = fetch_rsp_valid && (fetch_rsp_wfid == WF_ID_W'(i));
    end
  end

  assign eligible = active_q & ~pending_q & ~stop_fetch & ~br_hit & ~halt_hit;

  rr_arbiter_40 u_arb (
    .req      (eligible),
    .base     (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  always_comb begin
    state_d = state_q;
    pick    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: if (grant_any) begin
        pick    = 1'b1;
        state_d = ST_REQ;
      end
      ST_REQ: if (fetch_req_ready) begin
        accept  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    q_vtail_incr = '0;
    for (int i = 0; i < NUM_WF; i++) begin
      q_vtail_incr[i] = accept && (req_wfid_q == WF_ID_W'(i));
    end
  end

  assign fetch_req_valid = (state_q == ST_REQ);
  assign fetch_req_wfid  = req_wfid_q;
  assign fetch_req_pc    = req_pc_q;
  // A response racing a flush, halt or re-dispatch of its slot is stale.
  assign q_wr    = rsp_hit & ~drop_q & ~br_hit & ~halt_hit & ~disp_hit;
  assign q_reset = br_hit | disp_hit;
  assign req_hit = br_hit[req_wfid_q] | disp_hit[req_wfid_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      req_wfid_q <= '0;
      req_pc_q   <= '0;
      req_kill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pick) begin
        req_wfid_q <= grant_id;
        req_pc_q   <= pc_q[grant_id];
        req_kill_q <= 1'b0;
      end else if (fetch_req_valid && req_hit) begin
        req_kill_q <= 1'b1;
      end
      if (accept) rr_ptr_q <= wf_next(req_wfid_q);
    end
  end

  // PC write priority: dispatch, then branch, then post-fetch increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q  <= '0;
      pending_q <= '0;
      drop_q    <= '0;
      for (int i = 0; i < NUM_WF; i++) pc_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_WF; i++) begin
        if (disp_hit[i]) begin
          active_q[i]  <= 1'b1;
          pending_q[i] <= 1'b0;
          drop_q[i]    <= 1'b0;
          pc_q[i]      <= disp_pc;
        end else begin
          if (halt_hit[i]) active_q[i] <= 1'b0;
          if (pick && grant[i]) pending_q[i] <= 1'b1;
          else if (rsp_hit[i])  pending_q[i] <= 1'b0;
          if (rsp_hit[i]) drop_q[i] <= 1'b0;
          else if ((br_hit[i] || halt_hit[i]) && pending_q[i]) drop_q[i] <= 1'b1;
          if (br_hit[i]) pc_q[i] <= br_target;
          else if (q_vtail_incr[i] && !req_kill_q) pc_q[i] <= req_pc_q + PC_W'(4);
        end
      end
    end
  end

  a_disp_inactive: assert property (@(posedge clk) disable iff (!rst)
    disp_valid |-> (!active_q[disp_wfid] || halt_hit[disp_wfid]));
endmodule

// File: tb/tb_wavepool_fetch_scheduler.sv
// Directed scenarios plus randomized traffic against a slot-level reference model.
module tb_wavepool_fetch_scheduler;
  import wavepool_fetch_scheduler_pkg::*;

  logic               clk = 1'b0, rst = 1'b0;
  logic               disp_valid = 0, halt_valid = 0, br_valid = 0;
  logic [WF_ID_W-1:0] disp_wfid = 0, halt_wfid = 0, br_wfid = 0, fetch_rsp_wfid = 0;
  logic [PC_W-1:0]    disp_pc = 0, br_target = 0;
  logic [NUM_WF-1:0]  stop_fetch = '0;
  logic               fetch_req_ready = 0, fetch_rsp_valid = 0;
  logic               fetch_req_valid;
  logic [WF_ID_W-1:0] fetch_req_wfid;
  logic [PC_W-1:0]    fetch_req_pc;
  logic [NUM_WF-1:0]  q_vtail_incr, q_wr, q_reset;

  wavepool_fetch_scheduler dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_wfid(disp_wfid), .disp_pc(disp_pc),
    .halt_valid(halt_valid), .halt_wfid(halt_wfid),
    .br_valid(br_valid), .br_wfid(br_wfid), .br_target(br_target),
    .stop_fetch(stop_fetch),
    .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
    .fetch_req_wfid(fetch_req_wfid), .fetch_req_pc(fetch_req_pc),
    .fetch_rsp_valid(fetch_rsp_valid), .fetch_rsp_wfid(fetch_rsp_wfid),
    .q_vtail_incr(q_vtail_incr), .q_wr(q_wr), .q_reset(q_reset)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  int rsp_pct = 100;
  bit rdy = 0;
  logic [NUM_WF-1:0] stop_v = '0;
  int wfq[$];

  // Reference model: per-slot state plus the one outstanding request.
  bit              m_act[NUM_WF], m_pend[NUM_WF], m_drop[NUM_WF];
  logic [PC_W-1:0] m_pc[NUM_WF];
  int              m_rr, m_rq;
  bit              m_busy, m_kill;
  logic [PC_W-1:0] m_rq_pc;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NUM_WF; i++) begin
      m_act[i] = 0; m_pend[i] = 0; m_drop[i] = 0; m_pc[i] = '0;
    end
    m_rr = 0; m_rq = 0; m_busy = 0; m_kill = 0; m_rq_pc = '0;
  endfunction

  function automatic void model_step();
    int w; bit found;
    w = 0; found = 0;
    if (!m_busy) begin
      for (int k = 0; k < NUM_WF && !found; k++) begin
        w = (m_rr + k) % NUM_WF;
        if (m_act[w] && !m_pend[w] && !stop_fetch[w] &&
            !(br_valid && br_wfid == w) && !(halt_valid && halt_wfid == w)) found = 1;
      end
      if (found) begin
        m_busy = 1; m_rq = w; m_rq_pc = m_pc[w]; m_kill = 0; m_pend[w] = 1;
      end
    end else if (fetch_req_ready) begin
      m_busy = 0;
      if (!m_kill) m_pc[m_rq] = m_pc[m_rq] + 4;
      m_rr = (m_rq + 1) % NUM_WF;
    end else if ((br_valid && br_wfid == m_rq) || (disp_valid && disp_wfid == m_rq)) begin
      m_kill = 1;
    end
    if (fetch_rsp_valid) begin m_pend[fetch_rsp_wfid] = 0; m_drop[fetch_rsp_wfid] = 0; end
    if (br_valid) begin
      m_pc[br_wfid] = br_target;
      if (m_pend[br_wfid]) m_drop[br_wfid] = 1;
    end
    if (halt_valid) begin
      m_act[halt_wfid] = 0;
      if (m_pend[halt_wfid]) m_drop[halt_wfid] = 1;
    end
    if (disp_valid) begin
      m_act[disp_wfid] = 1; m_pc[disp_wfid] = disp_pc; m_pend[disp_wfid] = 0; m_drop[disp_wfid] = 0;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else begin cyc++; model_step(); end
  end

  always @(negedge clk) begin : compare
    logic [NUM_WF-1:0] one, e_v, e_w, e_r;
    if (rst) begin
      one = 1; e_v = '0; e_w = '0; e_r = '0;
      if (m_busy && fetch_req_ready) e_v = one << m_rq;
      if (fetch_rsp_valid && !m_drop[fetch_rsp_wfid] &&
          !(br_valid && br_wfid == fetch_rsp_wfid) &&
          !(halt_valid && halt_wfid == fetch_rsp_wfid) &&
          !(disp_valid && disp_wfid == fetch_rsp_wfid)) e_w = one << fetch_rsp_wfid;
      if (br_valid)   e_r = e_r | (one << br_wfid);
      if (disp_valid) e_r = e_r | (one << disp_wfid);
      chk("req_valid", fetch_req_valid, m_busy);
      if (m_busy) begin
        chk("req_wfid", fetch_req_wfid, m_rq);
        chk("req_pc", fetch_req_pc, m_rq_pc);
      end
      chk("q_vtail_incr", q_vtail_incr, e_v);
      chk("q_wr", q_wr, e_w);
      chk("q_reset", q_reset, e_r);
      if (fetch_req_valid && fetch_req_ready) wfq.push_back(int'(fetch_req_wfid));
    end
  end

  task automatic step();
    @(posedge clk); #1;
    disp_valid = 0; halt_valid = 0; br_valid = 0; fetch_rsp_valid = 0;
    fetch_req_ready = rdy; stop_fetch = stop_v;
    if (wfq.size() > 0 && $urandom_range(99) < rsp_pct) begin
      fetch_rsp_valid = 1; fetch_rsp_wfid = WF_ID_W'(wfq.pop_front());
    end
  endtask

  task automatic wait_req(input int max);
    bit ok; ok = 0;
    for (int i = 0; i < max && !ok; i++) begin
      step(); @(negedge clk);
      if (fetch_req_valid) ok = 1;
    end
    if (!ok) chk("req_timeout", 0, 1);
  endtask

  // Called at a negedge; asserts reset mid-cycle and releases it one cycle later.
  task automatic do_reset();
    #2; rst = 0;
    disp_valid = 0; halt_valid = 0; br_valid = 0; fetch_rsp_valid = 0;
    fetch_req_ready = 0; rdy = 0; stop_v = '0; stop_fetch = '0; rsp_pct = 100;
    #1;
    chk("rst_req_valid", fetch_req_valid, 0);
    chk("rst_vtail", q_vtail_incr, 0);
    wfq.delete();
    @(negedge clk); #2; rst = 1;
    @(negedge clk);
  endtask

  task automatic resp_now();
    if (wfq.size() == 0) chk("resp_queue_empty", 0, 1);
    else begin fetch_rsp_valid = 1; fetch_rsp_wfid = WF_ID_W'(wfq.pop_front()); end
  endtask

  task automatic disp(input int w, input logic [PC_W-1:0] pc);
    disp_valid = 1; disp_wfid = WF_ID_W'(w); disp_pc = pc;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int g_id[$], g_cy[$];
    repeat (2) @(negedge clk);
    chk("reset_req_valid", fetch_req_valid, 0);
    chk("reset_q_wr", q_wr, 0);
    chk("reset_q_reset", q_reset, 0);
    #2; rst = 1;
    @(negedge clk);

    // Dispatch wf3 at 0x100 with ready held high.
    rdy = 1;
    step(); disp(3, 32'h100);
    @(negedge clk); chk("b_q_reset", q_reset, 64'h8);
    step(); @(negedge clk); chk("b_pick_cycle_valid", fetch_req_valid, 0);
    step(); @(negedge clk);
    chk("b_valid", fetch_req_valid, 1);
    chk("b_wfid", fetch_req_wfid, 3);
    chk("b_pc", fetch_req_pc, 32'h100);
    chk("b_vtail", q_vtail_incr, 64'h8);
    step(); @(negedge clk);
    chk("b_model_pc", m_pc[3], 32'h104);
    wait_req(20);
    chk("b_next_pc", fetch_req_pc, 32'h104);

    // Round robin over wf0, wf5, wf39.
    do_reset(); rdy = 1;
    for (int i = 0; i < 20 && g_id.size() < 4; i++) begin
      step();
      if (i == 0) disp(0, 32'h0);
      if (i == 1) disp(5, 32'h500);
      if (i == 2) disp(39, 32'h3900);
      @(negedge clk);
      if (fetch_req_valid && fetch_req_ready) begin g_id.push_back(int'(fetch_req_wfid)); g_cy.push_back(cyc); end
    end
    chk("rr_count", g_id.size(), 4);
    if (g_id.size() == 4) begin
      chk("rr_g0", g_id[0], 0); chk("rr_g1", g_id[1], 5);
      chk("rr_g2", g_id[2], 39); chk("rr_g3", g_id[3], 0);
      for (int i = 1; i < 4; i++) chk("rr_spacing", g_cy[i] - g_cy[i-1], 2);
    end

    // Backpressure: five cycles of ready low.
    do_reset(); rdy = 0;
    step(); disp(9, 32'h900);
    wait_req(10);
    chk("bp_wfid", fetch_req_wfid, 9);
    chk("bp_vtail_hold", q_vtail_incr, 0);
    for (int i = 0; i < 4; i++) begin
      step(); @(negedge clk);
      chk("bp_valid", fetch_req_valid, 1);
      chk("bp_wfid_hold", fetch_req_wfid, 9);
      chk("bp_pc_hold", fetch_req_pc, 32'h900);
      chk("bp_vtail_hold", q_vtail_incr, 0);
    end
    rdy = 1; step(); @(negedge clk);
    chk("bp_vtail_accept", q_vtail_incr, 64'h200);
    step(); @(negedge clk);
    chk("bp_vtail_once", q_vtail_incr, 0);

    // stop_fetch[5] masks wf5 until released.
    do_reset(); rdy = 1; stop_v[5] = 1'b1;
    step(); disp(5, 32'h50);
    step(); disp(6, 32'h60);
    g_id.delete();
    for (int i = 0; i < 12; i++) begin
      step(); @(negedge clk);
      if (fetch_req_valid && fetch_req_ready) begin
        g_id.push_back(int'(fetch_req_wfid));
        chk("sf_only_wf6", fetch_req_wfid, 6);
      end
    end
    chk("sf_wf6_granted", g_id.size() >= 3, 1);
    stop_v = '0;
    wait_req(10);
    chk("sf_release_wf5", fetch_req_wfid, 5);

    // Redirect while a fetch is pending.
    do_reset(); rdy = 1; rsp_pct = 0;
    step(); disp(3, 32'h200);
    wait_req(10);
    chk("br_first_pc", fetch_req_pc, 32'h200);
    step(); br_valid = 1; br_wfid = 3; br_target = 32'h800;
    @(negedge clk); chk("br_q_reset", q_reset, 64'h8);
    step(); resp_now();
    @(negedge clk); chk("br_rsp_dropped", q_wr, 0);
    rsp_pct = 100;
    wait_req(10);
    chk("br_next_pc", fetch_req_pc, 32'h800);

    // Redirect and response for wf7 in the same cycle.
    do_reset(); rdy = 1; rsp_pct = 0;
    step(); disp(7, 32'h700);
    wait_req(10);
    step(); resp_now(); br_valid = 1; br_wfid = 7; br_target = 32'h40;
    @(negedge clk);
    chk("same_q_wr", q_wr, 0);
    chk("same_q_reset", q_reset, 64'h80);
    rsp_pct = 100;
    wait_req(10);
    chk("same_next_pc", fetch_req_pc, 32'h40);

    // Asynchronous reset while a request is held.
    do_reset(); rdy = 0;
    step(); disp(2, 32'h20);
    wait_req(10);
    chk("ar_valid_before", fetch_req_valid, 1);
    do_reset();

    // Randomized traffic.
    rsp_pct = 50;
    for (int n = 0; n < 3000; n++) begin
      int w;
      step();
      fetch_req_ready = ($urandom_range(3) != 0);
      stop_fetch = '0;
      if ($urandom_range(3) == 0) stop_fetch[$urandom_range(NUM_WF-1)] = 1'b1;
      w = $urandom_range(NUM_WF-1);
      if ($urandom_range(99) < 20 && !m_act[w] && !m_pend[w]) disp(w, $urandom & 32'hFFFF_FFFC);
      if ($urandom_range(99) < 8) begin
        br_valid = 1; br_wfid = WF_ID_W'($urandom_range(NUM_WF-1)); br_target = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(99) < 5) begin
        halt_valid = 1; halt_wfid = WF_ID_W'($urandom_range(NUM_WF-1));
      end
    end
    step(); @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
